// File: rtl/aucohl_pwm_seq_pkg.sv
// Shared types for the PWM profile sequencer: FSM encoding and table entry layout.
package aucohl_pwm_seq_pkg;

  localparam int unsigned ValW = 32;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StRun  = 2'd2,
    StDone = 2'd3
  } seq_state_e;

  typedef struct packed {
    logic [ValW-1:0] reload;
    logic [ValW-1:0] cmpx;
    logic [ValW-1:0] cmpy;
  } pwm_cfg_t;

endpackage

// File: rtl/aucohl_pwm_seq_if.sv
// Table write bus of the PWM sequencer; software side is master, sequencer is slave.
interface aucohl_pwm_seq_if
  import aucohl_pwm_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 8
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [ValW-1:0] wr_reload;
  logic [ValW-1:0] wr_cmpx;
  logic [ValW-1:0] wr_cmpy;
  logic [CW-1:0]   wr_rpt;

  modport master (
    output wr_en,
    output wr_addr,
    output wr_reload,
    output wr_cmpx,
    output wr_cmpy,
    output wr_rpt
  );

  modport slave (
    input wr_en,
    input wr_addr,
    input wr_reload,
    input wr_cmpx,
    input wr_cmpy,
    input wr_rpt
  );

endinterface

// File: rtl/aucohl_pwm_seq_tbl.sv
// DEPTH-entry profile table: one synchronous write port, one combinational read port.
module aucohl_pwm_seq_tbl
  import aucohl_pwm_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 8,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  pwm_cfg_t      wr_cfg_i,
  input  logic [CW-1:0] wr_rpt_i,
  input  logic [AW-1:0] rd_idx_i,
  output pwm_cfg_t      rd_cfg_o,
  output logic [CW-1:0] rd_rpt_o
);

  pwm_cfg_t      cfg_q [DEPTH];
  logic [CW-1:0] rpt_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        cfg_q[i] <= '0;
        rpt_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      cfg_q[wr_addr_i] <= wr_cfg_i;
      rpt_q[wr_addr_i] <= wr_rpt_i;
    end
  end

  // Read sees pre-write contents when a write to the same entry lands this cycle.
  assign rd_cfg_o = cfg_q[rd_idx_i];
  assign rd_rpt_o = rpt_q[rd_idx_i];

endmodule

// File: rtl/aucohl_pwm_seq.sv
// PWM profile sequencer: plays table entries for rpt+1 timer periods each and drives the timer.
module aucohl_pwm_seq
  import aucohl_pwm_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 8,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  aucohl_pwm_seq_if.slave wr_if,
  input  logic            seq_en_i,
  input  logic            seq_loop_i,
  input  logic [AW-1:0]   seq_last_i,
  input  logic            timeout_flag_i,
  output logic            tmr_en_o,
  output logic [ValW-1:0] tmr_reload_o,
  output logic [ValW-1:0] cmpx_o,
  output logic [ValW-1:0] cmpy_o,
  output logic [AW-1:0]   cur_idx_o,
  output logic            busy_o,
  output logic            done_o
);

  localparam logic [AW-1:0] LastMax = AW'(DEPTH - 1);

  seq_state_e    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [CW-1:0] rpt_q, rpt_d;
  pwm_cfg_t      cfg_q, cfg_d;
  logic          tmr_en_q, tmr_en_d;
  logic          done_q, done_d;
  logic          timeout_q;

  logic          pe;
  logic          load;
  logic [AW-1:0] ld_idx;
  logic [AW-1:0] eff_last;
  pwm_cfg_t      wr_cfg;
  pwm_cfg_t      tbl_cfg;
  logic [CW-1:0] tbl_rpt;

  assign wr_cfg.reload = wr_if.wr_reload;
  assign wr_cfg.cmpx   = wr_if.wr_cmpx;
  assign wr_cfg.cmpy   = wr_if.wr_cmpy;

  // Read port follows the entry about to be loaded so outputs change on the decision edge.
  aucohl_pwm_seq_tbl #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_tbl (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (wr_if.wr_en),
    .wr_addr_i (wr_if.wr_addr),
    .wr_cfg_i  (wr_cfg),
    .wr_rpt_i  (wr_if.wr_rpt),
    .rd_idx_i  (ld_idx),
    .rd_cfg_o  (tbl_cfg),
    .rd_rpt_o  (tbl_rpt)
  );

  assign pe       = timeout_flag_i & ~timeout_q;
  assign eff_last = (seq_last_i > LastMax) ? LastMax : seq_last_i;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rpt_d    = rpt_q;
    cfg_d    = cfg_q;
    tmr_en_d = tmr_en_q;
    done_d   = 1'b0;
    load     = 1'b0;
    ld_idx   = '0;

    if (!seq_en_i) begin
      state_d  = StIdle;
      tmr_en_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          load    = 1'b1;
          state_d = StLoad;
        end
        StLoad: begin
          // Enable rises only here; reloads from RUN keep it high so the timer never restarts.
          state_d  = StRun;
          tmr_en_d = 1'b1;
        end
        StRun: begin
          if (pe) begin
            if (rpt_q != '0) begin
              rpt_d = rpt_q - 1'b1;
            end else if (idx_q < eff_last) begin
              load    = 1'b1;
              ld_idx  = idx_q + 1'b1;
              state_d = StLoad;
            end else if (seq_loop_i) begin
              load    = 1'b1;
              state_d = StLoad;
            end else begin
              state_d  = StDone;
              tmr_en_d = 1'b0;
              done_d   = 1'b1;
            end
          end
        end
        StDone: ;
        default: state_d = StIdle;
      endcase
    end

    if (load) begin
      idx_d = ld_idx;
      rpt_d = tbl_rpt;
      cfg_d = tbl_cfg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      rpt_q     <= '0;
      cfg_q     <= '0;
      tmr_en_q  <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rpt_q     <= rpt_d;
      cfg_q     <= cfg_d;
      tmr_en_q  <= tmr_en_d;
      done_q    <= done_d;
      timeout_q <= timeout_flag_i;
    end
  end

  assign tmr_en_o     = tmr_en_q;
  assign tmr_reload_o = cfg_q.reload;
  assign cmpx_o       = cfg_q.cmpx;
  assign cmpy_o       = cfg_q.cmpy;
  assign cur_idx_o    = idx_q;
  assign busy_o       = (state_q == StLoad) || (state_q == StRun);
  assign done_o       = done_q;

endmodule

// File: tb/tb_aucohl_pwm_seq.sv
// Bench for aucohl_pwm_seq: hand sequences, a vector table and randomized runs against a model.
module tb_aucohl_pwm_seq;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 8;
  localparam int unsigned AW    = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          seq_en, seq_loop, timeout_flag;
  logic [AW-1:0] seq_last;
  logic          tmr_en, busy, done;
  logic [31:0]   tmr_reload, cmpx, cmpy;
  logic [AW-1:0] cur_idx;

  always #5 clk = ~clk;

  aucohl_pwm_seq_if #(.DEPTH(DEPTH), .CW(CW)) wr_if ();

  aucohl_pwm_seq #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wr_if          (wr_if),
    .seq_en_i       (seq_en),
    .seq_loop_i     (seq_loop),
    .seq_last_i     (seq_last),
    .timeout_flag_i (timeout_flag),
    .tmr_en_o       (tmr_en),
    .tmr_reload_o   (tmr_reload),
    .cmpx_o         (cmpx),
    .cmpy_o         (cmpy),
    .cur_idx_o      (cur_idx),
    .busy_o         (busy),
    .done_o         (done)
  );

  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  always @(negedge clk) if (done === 1'b1) done_seen++;

  // Shadow of the table as software wrote it.
  logic [31:0] sh_reload [DEPTH];
  logic [31:0] sh_cmpx   [DEPTH];
  logic [31:0] sh_cmpy   [DEPTH];
  int          sh_rpt    [DEPTH];

  // Reference model: which entry is playing and how many period edges it still owns.
  bit          m_act;
  int          m_idx, m_left, m_done, m_last, m_loop;
  logic [31:0] m_rl, m_cx, m_cy;

  typedef struct {
    int last;
    int loop;
    int edges;
    int idx;
    int cmpx;
    int ten;
    int bsy;
    int dn;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input int a, input logic [31:0] rl, input logic [31:0] cx,
                    input logic [31:0] cy, input int rp);
    wr_if.wr_en     = 1'b1;
    wr_if.wr_addr   = AW'(a);
    wr_if.wr_reload = rl;
    wr_if.wr_cmpx   = cx;
    wr_if.wr_cmpy   = cy;
    wr_if.wr_rpt    = CW'(rp);
    sh_reload[a] = rl;
    sh_cmpx[a]   = cx;
    sh_cmpy[a]   = cy;
    sh_rpt[a]    = rp;
    cyc(1);
    wr_if.wr_en = 1'b0;
  endtask

  task automatic pulse(input int h, input int g);
    timeout_flag = 1'b1;
    cyc(h);
    timeout_flag = 1'b0;
    cyc(g);
  endtask

  task automatic start_seq();
    seq_en = 1'b0;
    cyc(2);
    seq_en = 1'b1;
    cyc(3);
  endtask

  function automatic void m_load(input int i);
    m_idx  = i;
    m_left = sh_rpt[i] + 1;
    m_rl   = sh_reload[i];
    m_cx   = sh_cmpx[i];
    m_cy   = sh_cmpy[i];
  endfunction

  function automatic void m_edge();
    int last;
    if (!m_act) return;
    last = (m_last > DEPTH - 1) ? DEPTH - 1 : m_last;
    m_left--;
    if (m_left == 0) begin
      if (m_idx < last) m_load(m_idx + 1);
      else if (m_loop != 0) m_load(0);
      else begin
        m_act = 1'b0;
        m_done++;
      end
    end
  endfunction

  task automatic m_check();
    chk("rnd_idx", 32'(cur_idx), 32'(m_idx));
    chk("rnd_reload", tmr_reload, m_rl);
    chk("rnd_cmpx", cmpx, m_cx);
    chk("rnd_cmpy", cmpy, m_cy);
    chk("rnd_tmr_en", 32'(tmr_en), 32'(m_act));
    chk("rnd_busy", 32'(busy), 32'(m_act));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int d0, md0;
    vecs[0]  = '{1, 0, 0, 0,  25, 1, 1, 0};
    vecs[1]  = '{1, 0, 1, 0,  25, 1, 1, 0};
    vecs[2]  = '{1, 0, 2, 1,  50, 1, 1, 0};
    vecs[3]  = '{1, 0, 3, 1,  50, 0, 0, 1};
    vecs[4]  = '{1, 0, 5, 1,  50, 0, 0, 1};
    vecs[5]  = '{1, 1, 3, 0,  25, 1, 1, 0};
    vecs[6]  = '{1, 1, 5, 1,  50, 1, 1, 0};
    vecs[7]  = '{7, 0, 4, 3, 100, 1, 1, 0};
    vecs[8]  = '{7, 0, 7, 3, 100, 0, 0, 1};
    vecs[9]  = '{0, 0, 2, 0,  25, 0, 0, 1};
    vecs[10] = '{2, 1, 4, 0,  25, 1, 1, 0};

    for (int i = 0; i < DEPTH; i++) begin
      sh_reload[i] = '0; sh_cmpx[i] = '0; sh_cmpy[i] = '0; sh_rpt[i] = 0;
    end
    rst_n = 1'b0; seq_en = 1'b0; seq_loop = 1'b0; seq_last = '0; timeout_flag = 1'b0;
    wr_if.wr_en = 1'b0; wr_if.wr_addr = '0; wr_if.wr_reload = '0;
    wr_if.wr_cmpx = '0; wr_if.wr_cmpy = '0; wr_if.wr_rpt = '0;
    cyc(2);
    chk("rst_tmr_en", 32'(tmr_en), 0);
    chk("rst_reload", tmr_reload, 0);
    chk("rst_cmpx", cmpx, 0);
    chk("rst_cmpy", cmpy, 0);
    chk("rst_idx", 32'(cur_idx), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    rst_n = 1'b1;
    cyc(1);

    wr(0, 100, 25, 50, 1);
    wr(1, 200, 50, 150, 0);
    wr(2, 300, 75, 250, 0);
    wr(3, 400, 100, 350, 2);

    // Start latency and the basic one-shot sequence
    seq_last = 2'd1; seq_loop = 1'b0; seq_en = 1'b1;
    cyc(1);
    chk("lat_busy", 32'(busy), 1);
    chk("lat_tmr_en0", 32'(tmr_en), 0);
    chk("lat_reload", tmr_reload, 100);
    chk("lat_cmpx", cmpx, 25);
    chk("lat_cmpy", cmpy, 50);
    cyc(1);
    chk("lat_tmr_en1", 32'(tmr_en), 1);
    pulse(1, 2);
    chk("basic_e0_idx", 32'(cur_idx), 0);
    timeout_flag = 1'b1;
    cyc(1);
    chk("basic_e1_idx", 32'(cur_idx), 1);
    chk("basic_e1_cmpx", cmpx, 50);
    chk("basic_e1_reload", tmr_reload, 200);
    timeout_flag = 1'b0;
    cyc(2);
    timeout_flag = 1'b1;
    cyc(1);
    chk("basic_done_pulse", 32'(done), 1);
    chk("basic_done_tmr_en", 32'(tmr_en), 0);
    chk("basic_done_busy", 32'(busy), 0);
    chk("basic_done_cmpx", cmpx, 50);
    timeout_flag = 1'b0;
    cyc(1);
    chk("basic_done_width", 32'(done), 0);
    cyc(3);
    chk("basic_no_restart", 32'(busy), 0);

    // Level flag held high advances once
    seq_loop = 1'b1;
    start_seq();
    pulse(5, 2);
    chk("level_idx", 32'(cur_idx), 0);
    pulse(1, 3);
    chk("level_next_idx", 32'(cur_idx), 1);
    pulse(1, 3);
    chk("loop_wrap_idx", 32'(cur_idx), 0);
    chk("loop_tmr_en", 32'(tmr_en), 1);

    // Write to the active entry is deferred to its next load
    wr(0, 100, 77, 50, 1);
    chk("wrrun_hold0", cmpx, 25);
    pulse(1, 3);
    chk("wrrun_hold1", cmpx, 25);
    pulse(1, 3);
    pulse(1, 3);
    chk("wrrun_new", cmpx, 77);
    wr(0, 100, 25, 50, 1);

    // Write and load of the same entry in one cycle: load gets old contents
    pulse(1, 3);
    timeout_flag = 1'b1;
    wr_if.wr_en = 1'b1; wr_if.wr_addr = 2'd1; wr_if.wr_reload = 200;
    wr_if.wr_cmpx = 99; wr_if.wr_cmpy = 150; wr_if.wr_rpt = '0;
    cyc(1);
    timeout_flag = 1'b0; wr_if.wr_en = 1'b0;
    cyc(2);
    chk("wrload_old_idx", 32'(cur_idx), 1);
    chk("wrload_old_cmpx", cmpx, 50);
    pulse(1, 3);
    pulse(1, 3);
    pulse(1, 3);
    chk("wrload_new_cmpx", cmpx, 99);
    wr(1, 200, 50, 150, 0);
    pulse(1, 3);
    pulse(1, 3);
    pulse(1, 3);

    // Abort at entry 1, then restart from entry 0
    chk("abort_pre_idx", 32'(cur_idx), 1);
    seq_en = 1'b0;
    cyc(1);
    chk("abort_tmr_en", 32'(tmr_en), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_cmpx", cmpx, 50);
    seq_en = 1'b1;
    cyc(1);
    chk("restart_idx", 32'(cur_idx), 0);
    chk("restart_cmpx", cmpx, 25);
    cyc(1);
    chk("restart_tmr_en", 32'(tmr_en), 1);

    for (int i = 0; i < 11; i++) begin
      seq_last = AW'(vecs[i].last);
      seq_loop = vecs[i].loop[0];
      d0 = done_seen;
      start_seq();
      for (int e = 0; e < vecs[i].edges; e++) pulse(1, 3);
      chk($sformatf("row%0d_idx", i), 32'(cur_idx), vecs[i].idx);
      chk($sformatf("row%0d_cmpx", i), cmpx, vecs[i].cmpx);
      chk($sformatf("row%0d_tmr_en", i), 32'(tmr_en), vecs[i].ten);
      chk($sformatf("row%0d_busy", i), 32'(busy), vecs[i].bsy);
      chk($sformatf("row%0d_done", i), done_seen - d0, vecs[i].dn);
    end

    // Asynchronous reset mid-run clears outputs at once and wipes the table
    seq_last = 2'd1; seq_loop = 1'b1;
    start_seq();
    pulse(1, 3);
    pulse(1, 3);
    rst_n = 1'b0;
    #1;
    chk("arst_tmr_en", 32'(tmr_en), 0);
    chk("arst_reload", tmr_reload, 0);
    chk("arst_cmpx", cmpx, 0);
    chk("arst_cmpy", cmpy, 0);
    chk("arst_idx", 32'(cur_idx), 0);
    chk("arst_busy", 32'(busy), 0);
    seq_en = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      sh_reload[i] = '0; sh_cmpx[i] = '0; sh_cmpy[i] = '0; sh_rpt[i] = 0;
    end
    cyc(1);
    seq_en = 1'b1;
    cyc(3);
    chk("arst_tbl_reload", tmr_reload, 0);
    chk("arst_tbl_cmpx", cmpx, 0);
    chk("arst_tbl_cmpy", cmpy, 0);
    chk("arst_run", 32'(tmr_en), 1);

    // Randomized tables, pulse widths and mid-run writes against the model
    m_done = 0;
    for (int r = 0; r < 4; r++) begin
      seq_en = 1'b0;
      for (int e = 0; e < DEPTH; e++) wr(e, $urandom, $urandom, $urandom, $urandom_range(0, 2));
      m_last = $urandom_range(0, DEPTH - 1);
      m_loop = $urandom_range(0, 1);
      seq_last = AW'(m_last);
      seq_loop = m_loop[0];
      md0 = m_done;
      d0 = done_seen;
      cyc(2);
      seq_en = 1'b1;
      m_act = 1'b1;
      m_load(0);
      cyc(3);
      m_check();
      for (int p = 0; p < 15; p++) begin
        timeout_flag = 1'b1;
        cyc($urandom_range(1, 4));
        timeout_flag = 1'b0;
        m_edge();
        if ($urandom_range(0, 3) == 0)
          wr($urandom_range(0, DEPTH - 1), $urandom, $urandom, $urandom, $urandom_range(0, 2));
        cyc(2);
        m_check();
      end
      chk("rnd_done_count", done_seen - d0, m_done - md0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aucohl_pwm_seq.md
# aucohl_pwm_seq

PWM profile sequencer that sits in front of the 32-bit timer/PWM block and drives its `tmr_en`, `tmr_reload`, `cmpx` and `cmpy` inputs. It holds a small table of period/compare entries. Each entry is played for a programmed number of timer periods, then the sequencer advances to the next entry on the timer's period boundary. It supports one-shot and looping sequences, so software can generate ramps and bursts without servicing every period.

## Interface
Parameters:
- DEPTH, 4: number of table entries (power of two, 2..16); AW = clog2(DEPTH).
- CW, 8: repeat-count width.

Ports:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  reset; asynchronous, active-low.
- seq_en  in  1  level; high = run sequence, low = abort/idle.
- seq_loop  in  1  1: wrap to entry 0 after the last entry; 0: stop.
- seq_last  in  AW  index of the last entry played.
- wr_en  in  1  table write strobe.
- wr_addr  in  AW  table entry written.
- wr_reload  in  32  reload value of the entry.
- wr_cmpx  in  32  CMPX value of the entry.
- wr_cmpy  in  32  CMPY value of the entry.
- wr_rpt  in  CW  repeat count; the entry plays wr_rpt+1 periods.
- timeout_flag  in  1  timer period-end flag (level; may stay high for several cycles).
- tmr_en  out  1  timer enable.
- tmr_reload  out  32  to timer.
- cmpx  out  32  to timer.
- cmpy  out  32  to timer.
- cur_idx  out  AW  entry currently driven.
- busy  out  1  high in LOAD/RUN.
- done  out  1  one-cycle pulse on sequence completion.

## Operation
- Reset values: every output is 0; the table is cleared; the state machine is in IDLE.
- Table: DEPTH registers of {reload, cmpx, cmpy, rpt}.
  - wr_en writes the table in any state.
  - A write never alters the current tmr_reload/cmpx/cmpy/rpt_cnt. It takes effect when that entry is next loaded.
  - A write and a load of the same index in the same cycle: the load takes the old contents.
- Period edge: pe = timeout_flag & ~timeout_q, where timeout_q is timeout_flag registered. Only rising edges count.
- Effective last index: eff_last = min(seq_last, DEPTH-1).
- States:
  - IDLE: tmr_en=0, busy=0. If seq_en=1, go to LOAD with idx=0.
  - LOAD, one cycle:
    - Drive tmr_reload/cmpx/cmpy from entry idx, set cur_idx=idx, rpt_cnt=entry.rpt.
    - tmr_en=1 from the next cycle, so the timer sees an enable edge on the first load only.
    - Go to RUN.
  - RUN: on pe:
    - If rpt_cnt≠0: decrement rpt_cnt.
    - Else if idx<eff_last: idx+1, go to LOAD.
    - Else if seq_loop=1: idx=0, go to LOAD.
    - Else: go to DONE.
    - Re-entering LOAD from RUN keeps tmr_en=1 (no timer restart).
  - DONE: tmr_en=0, busy=0, done=1 for the entry cycle only, outputs hold the last entry. Stay in DONE until seq_en=0.
- seq_en=0 in any state: go to IDLE the next cycle; tmr_en=0 in that cycle; compare outputs hold their values.
- Restart needs seq_en to go low and then high again. DONE never restarts while seq_en stays high.
- pe arriving while in LOAD is ignored, and timeout_q still updates.
- seq_loop and seq_last are sampled at every advance decision, so changes mid-sequence take effect at the next boundary.

## Timing
- Latency from seq_en rising in IDLE:
  - LOAD the next cycle, outputs valid at the end of that cycle.
  - tmr_en=1 one cycle after outputs are valid (2 cycles after seq_en).
- Latency from timeout_flag rising (cycle T):
  - pe is registered at T.
  - The state change and new compare outputs appear at T+1, with LOAD in T+1 and RUN at T+2.
- Timeout pulses closer than 2 cycles apart are unsupported. The timer's prescaled tick guarantees the spacing when prescaler ≥ 1.
- An entry with rpt=N is driven for exactly N+1 period edges.
- done pulses 1 cycle after the final pe.
- Asynchronous reset mid-sequence: all outputs drop to 0 immediately; the table is cleared.

## Structure
- Shared package or header holds:
  - state encoding: IDLE=2'd0, LOAD=2'd1, RUN=2'd2, DONE=2'd3;
  - entry field widths.
- The asynchronous-reset register idiom comes from the common RTL header.
- Sub-module `aucohl_pwm_seq_tbl` implements the DEPTH-entry register file: one write port, one combinational read port indexed by idx.
- The FSM, rpt_cnt and edge detector stay in the top module.

## Test plan
- Basic sequence:
  - Stimulus: entries 0/1 = {100,25,50,rpt 1}/{200,50,150,rpt 0}; seq_last=1, seq_loop=0; raise seq_en; 3 timeout rising edges.
  - Response: outputs show entry 0 for 2 edges, then entry 1; done pulses once, one cycle after the 3rd edge; tmr_en=0 after it.
- Looping:
  - Stimulus: same table with seq_loop=1; 6 edges.
  - Response: cur_idx goes 0,0,1,0,0,1; done is never asserted; tmr_en stays high.
- Abort:
  - Stimulus: drop seq_en during RUN at entry 1.
  - Response: IDLE and tmr_en=0 the next cycle; cmpx holds 50; re-raising seq_en reloads entry 0.
- Write during run:
  - Stimulus: write entry 0 cmpx=77 while entry 0 is active.
  - Response: cmpx stays 25 until entry 0 is next loaded, then reads 77.
- Level flag and clamp:
  - Stimulus: hold timeout_flag high for 5 cycles; seq_last=7 with DEPTH=4.
  - Response: one advance only per high period; the sequence ends after index 3.
- Reset:
  - Stimulus: assert rst_n low mid-RUN.
  - Response: all outputs read 0 immediately; a table read after reset returns 0.
